// File: rtl/img_pkg.sv
// Shared widths, luma coefficients, RGB field positions and FSM states
// for the BRAM-to-luma read-out path.
package img_pkg;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 24;
    localparam int Y_W    = 8;
    localparam int CH_W   = 8;
    localparam int MARK_W = 3;

    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head entry,
// presented combinationally and held until it is popped.
module sync_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only legal when the head leaves the same cycle.
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clka) begin
        if (!rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/bram_gray_streamer.sv
// Walks the image BRAM once per start, converts RGB888 to 8-bit luma and
// streams it out with frame/line markers under credit-limited backpressure.
module bram_gray_streamer
    import img_pkg::*;
#(
    parameter int WIDTH      = 136,
    parameter int HEIGHT     = 140,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    input  logic [PIX_W-1:0]  douta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [Y_W-1:0]    m_pix,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int FW   = MARK_W + Y_W;

    function automatic logic [Y_W-1:0] luma(input logic [PIX_W-1:0] rgb);
        logic [15:0] acc;
        acc = 16'(COEF_R) * 16'(rgb[R_LSB +: CH_W])
            + 16'(COEF_G) * 16'(rgb[G_LSB +: CH_W])
            + 16'(COEF_B) * 16'(rgb[B_LSB +: CH_W]);
        return acc[15 -: Y_W];
    endfunction

    state_t                state;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     ret_idx;
    logic [ADDR_W-1:0]     ret_col;
    logic [RD_LATENCY-1:0] vld_p;
    logic [CW:0]           inflight;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  issue;
    logic                  wr_en;
    logic                  rd_en;
    logic [FW-1:0]         wr_word;
    logic [FW-1:0]         rd_word;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (CW+1)'(vld_p[i]);
    end

    // Credits cover both queued entries and reads whose data has not returned yet.
    assign issue = (state == ST_RUN) &&
                   (({1'b0, fifo_count} + inflight) < (CW+1)'(FIFO_DEPTH));

    assign ena   = issue;
    assign wea   = 1'b0;
    assign addra = rd_addr;

    // Stage boundary: BRAM return -> FIFO write, tagged with markers.
    assign wr_en   = vld_p[RD_LATENCY-1];
    assign wr_word = {ret_idx == ADDR_W'(NPIX - 1),
                      ret_col == ADDR_W'(WIDTH - 1),
                      ret_idx == '0,
                      luma(douta)};

    sync_fifo #(.DATA_W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clka    (clka),
        .rsta    (rsta),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Stage boundary: FIFO head -> stream output; masked so idle outputs read as zero.
    assign m_valid = !fifo_empty;
    assign rd_en   = m_valid && m_ready;
    assign m_pix   = m_valid ? rd_word[Y_W-1:0] : '0;
    assign m_sof   = m_valid && rd_word[Y_W];
    assign m_eol   = m_valid && rd_word[Y_W+1];
    assign m_last  = m_valid && rd_word[Y_W+2];

    always_ff @(posedge clka) begin
        if (!rsta) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_addr == ADDR_W'(NPIX - 1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_en && rd_word[Y_W+2]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (!rsta) begin
            vld_p   <= '0;
            ret_idx <= '0;
            ret_col <= '0;
        end else begin
            vld_p <= RD_LATENCY'({vld_p, issue});
            if (state == ST_IDLE && start) begin
                ret_idx <= '0;
                ret_col <= '0;
            end else if (wr_en) begin
                ret_idx <= ret_idx + ADDR_W'(1);
                ret_col <= (ret_col == ADDR_W'(WIDTH - 1)) ? '0 : ret_col + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bram_gray_streamer.sv
// Bench for bram_gray_streamer: a default-size instance and a small
// 4x3, two-cycle-latency instance, both fed from a randomised BRAM image.
module tb_bram_gray_streamer;
    localparam int W0 = 136, H0 = 140, N0 = W0 * H0, L0 = 1;
    localparam int W1 = 4,   H1 = 3,   N1 = W1 * H1, L1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rsta, start, ena, wea, m_valid, m_ready, m_sof, m_eol, m_last, busy, done;
    logic [14:0] addra;
    logic [23:0] douta;
    logic [7:0]  m_pix;

    logic        s_start, s_ena, s_wea, s_m_valid, s_ready, s_m_sof, s_m_eol, s_m_last, s_busy, s_done;
    logic [14:0] s_addra;
    logic [23:0] s_douta;
    logic [7:0]  s_m_pix;

    logic [23:0] mem [32768];
    logic [23:0] q0, s_q1, s_q2;

    int vectors = 0;
    int miscompares = 0;
    int corner_y [4] = '{255, 0, 76, 149};

    always @(posedge clk) if (ena) q0 <= mem[addra];
    assign douta = q0;
    always @(posedge clk) begin
        if (s_ena) s_q1 <= mem[s_addra];
        s_q2 <= s_q1;
    end
    assign s_douta = s_q2;

    bram_gray_streamer #(.WIDTH(W0), .HEIGHT(H0), .RD_LATENCY(L0), .FIFO_DEPTH(4)) dut (
        .clka(clk), .rsta(rsta), .start(start), .ena(ena), .wea(wea), .addra(addra),
        .douta(douta), .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix),
        .m_sof(m_sof), .m_eol(m_eol), .m_last(m_last), .busy(busy), .done(done));

    bram_gray_streamer #(.WIDTH(W1), .HEIGHT(H1), .RD_LATENCY(L1), .FIFO_DEPTH(4)) dut_s (
        .clka(clk), .rsta(rsta), .start(s_start), .ena(s_ena), .wea(s_wea), .addra(s_addra),
        .douta(s_douta), .m_valid(s_m_valid), .m_ready(s_ready), .m_pix(s_m_pix),
        .m_sof(s_m_sof), .m_eol(s_m_eol), .m_last(s_m_last), .busy(s_busy), .done(s_done));

    // Reference: pixel k of a w-wide, n-pixel frame as {last, eol, sof, luma}.
    function automatic logic [10:0] expect_word(int k, int w, int n);
        int r, g, b, y;
        logic [23:0] c;
        c = mem[k];
        r = c[23:16];
        g = c[15:8];
        b = c[7:0];
        y = (77 * r + 150 * g + 29 * b) / 256;
        return {k == n - 1, (k % w) == w - 1, k == 0, 8'(y)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rsta = 1'b0; start = 1'b1; s_start = 1'b1; m_ready = 1'b0; s_ready = 1'b0;
        repeat (3) tick();
        start = 1'b0; s_start = 1'b0;
        vectors++;
        if ({ena, wea, addra} !== 17'd0) begin
            miscompares++; $display("FAIL reset_bram: got %h want 0", {ena, wea, addra});
        end
        vectors++;
        if ({m_valid, m_pix, m_sof, m_eol, m_last} !== 12'd0) begin
            miscompares++; $display("FAIL reset_stream: got %h want 0", {m_valid, m_pix, m_sof, m_eol, m_last});
        end
        vectors++;
        if ({busy, done, s_busy, s_done, s_ena, s_m_valid} !== 6'd0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, s_busy, s_done, s_ena, s_m_valid});
        end
        rsta = 1'b1;
        tick();
        vectors++;
        if ({busy, ena, s_busy} !== 3'd0) begin
            miscompares++; $display("FAIL reset_release: got %b want 000", {busy, ena, s_busy});
        end
    endtask

    task automatic test_full_frame();
        int k, t, issued, first_v, last_hs, dones;
        logic [10:0] obs, exp_w;
        k = 0; issued = 0; first_v = -1; last_hs = -1; dones = 0;
        m_ready = 1'b1;
        start = 1'b1;
        tick();
        for (t = 1; t < N0 + 40; t++) begin
            start = (t == 500 || t == N0 + 1);
            if (t == 1) begin
                vectors++;
                if ({busy, ena, addra} !== {2'b11, 15'd0}) begin
                    miscompares++; $display("FAIL first_read: got %h want %h", {busy, ena, addra}, {2'b11, 15'd0});
                end
            end
            if (t == N0 + 1) begin
                vectors++;
                if ({busy, ena} !== 2'b10) begin
                    miscompares++; $display("FAIL drain_no_read: got %b want 10", {busy, ena});
                end
            end
            if (ena) begin
                vectors++;
                if (addra !== 15'(issued)) begin
                    miscompares++; $display("FAIL addr[%0d]: got %0d want %0d", issued, addra, issued);
                end
                issued++;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = t;
                obs = {m_last, m_eol, m_sof, m_pix};
                exp_w = expect_word(k, W0, N0);
                vectors++;
                if (obs !== exp_w) begin
                    miscompares++; $display("FAIL pix[%0d]: got %h want %h", k, obs, exp_w);
                end
                if (k < 4) begin
                    vectors++;
                    if (int'(m_pix) != corner_y[k]) begin
                        miscompares++; $display("FAIL corner[%0d]: got %0d want %0d", k, m_pix, corner_y[k]);
                    end
                end
                if (m_last) last_hs = t;
                k++;
            end
            if (done) begin
                dones++;
                vectors++;
                if (t != last_hs + 1 || busy !== 1'b0) begin
                    miscompares++; $display("FAIL done_timing: got cycle %0d busy %b want cycle %0d busy 0", t, busy, last_hs + 1);
                end
            end
            tick();
        end
        start = 1'b0;
        vectors++;
        if (first_v != L0 + 2) begin
            miscompares++; $display("FAIL first_valid: got %0d want %0d", first_v, L0 + 2);
        end
        vectors++;
        if (last_hs != N0 + L0 + 1) begin
            miscompares++; $display("FAIL last_handshake: got %0d want %0d", last_hs, N0 + L0 + 1);
        end
        vectors++;
        if (k != N0 || dones != 1) begin
            miscompares++; $display("FAIL frame_count: got %0d pixels %0d dones want %0d pixels 1 done", k, dones, N0);
        end
    endtask

    task automatic test_mid_reset();
        int k, t;
        logic [10:0] obs, exp_w;
        k = 0;
        m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (t = 1; t < 200 && k < 50; t++) begin
            if (m_valid) k++;
            tick();
        end
        vectors++;
        if (k != 50 || m_valid !== 1'b1) begin
            miscompares++; $display("FAIL reach_pixel50: got %0d valid %b want 50 valid 1", k, m_valid);
        end
        rsta = 1'b0;
        tick();
        rsta = 1'b1;
        vectors++;
        if ({ena, addra, m_valid, m_pix, m_sof, m_eol, m_last, busy, done} !== 29'd0) begin
            miscompares++; $display("FAIL midreset_outputs: got %h want 0",
                                    {ena, addra, m_valid, m_pix, m_sof, m_eol, m_last, busy, done});
        end
        for (t = 0; t < 30; t++) begin
            tick();
            vectors++;
            if ({m_valid, ena} !== 2'b00) begin
                miscompares++; $display("FAIL midreset_quiet[%0d]: got %b want 00", t, {m_valid, ena});
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({ena, addra} !== 16'h8000) begin
            miscompares++; $display("FAIL restart_addr: got %h want 8000", {ena, addra});
        end
        k = 0;
        for (t = 1; t < 100 && k < 20; t++) begin
            if (m_valid) begin
                obs = {m_last, m_eol, m_sof, m_pix};
                exp_w = expect_word(k, W0, N0);
                vectors++;
                if (obs !== exp_w) begin
                    miscompares++; $display("FAIL restart_pix[%0d]: got %h want %h", k, obs, exp_w);
                end
                k++;
            end
            tick();
        end
        rsta = 1'b0;
        tick();
        rsta = 1'b1;
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 4; f++) begin
            int issued, popped, k, t, first_v, dones;
            logic hold;
            logic [10:0] held, obs, exp_w;
            for (int i = 0; i < N1; i++) mem[i] = 24'($urandom);
            issued = 0; popped = 0; k = 0; first_v = -1; dones = 0; hold = 1'b0; held = '0;
            s_ready = 1'b0;
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            for (t = 1; t < 400 && dones == 0; t++) begin
                obs = {s_m_last, s_m_eol, s_m_sof, s_m_pix};
                if (s_ena) begin
                    vectors++;
                    if (s_addra !== 15'(issued)) begin
                        miscompares++; $display("FAIL s_addr[%0d]: got %0d want %0d", issued, s_addra, issued);
                    end
                    issued++;
                end
                vectors++;
                if (issued - popped > 4) begin
                    miscompares++; $display("FAIL credit: got %0d outstanding want at most 4", issued - popped);
                end
                if (hold) begin
                    vectors++;
                    if (s_m_valid !== 1'b1 || obs !== held) begin
                        miscompares++; $display("FAIL stall_hold: got valid %b %h want valid 1 %h", s_m_valid, obs, held);
                    end
                end
                s_ready = ($urandom_range(0, 99) < 30);
                if (s_m_valid && first_v < 0) first_v = t;
                hold = s_m_valid && !s_ready;
                held = obs;
                if (s_m_valid && s_ready) begin
                    exp_w = expect_word(k, W1, N1);
                    vectors++;
                    if (obs !== exp_w) begin
                        miscompares++; $display("FAIL s_pix[%0d]: got %h want %h", k, obs, exp_w);
                    end
                    k++;
                    popped++;
                end
                if (s_done) begin
                    dones++;
                    vectors++;
                    if (s_busy !== 1'b0) begin
                        miscompares++; $display("FAIL s_busy_fall: got %b want 0", s_busy);
                    end
                end
                tick();
            end
            s_ready = 1'b0;
            vectors++;
            if (first_v != L1 + 2) begin
                miscompares++; $display("FAIL s_first_valid: got %0d want %0d", first_v, L1 + 2);
            end
            vectors++;
            if (k != N1 || issued != N1 || dones != 1) begin
                miscompares++; $display("FAIL s_frame: got %0d pixels %0d reads %0d dones want %0d %0d 1",
                                        k, issued, dones, N1, N1);
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        rsta = 1'b0; start = 1'b0; s_start = 1'b0; m_ready = 1'b0; s_ready = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 24'($urandom);
        mem[0] = 24'hFFFFFF;
        mem[1] = 24'h000000;
        mem[2] = 24'hFF0000;
        mem[3] = 24'h00FF00;
        test_reset();
        test_full_frame();
        test_mid_reset();
        test_random_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
